// File: rtl/line_window_reader_if.sv
// Pixel-stream and window-output bundle for line_window_reader.
// The slave modport is the window reader; the master modport is the pixel producer / window consumer.
interface line_window_reader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
);
   logic                          in_valid;
   logic [DATA_WIDTH-1:0]         in_data;
   logic                          out_valid;
   logic [9*DATA_WIDTH-1:0]       out_win;
   logic [$clog2(IMG_HEIGHT)-1:0] out_row;
   logic [$clog2(IMG_WIDTH)-1:0]  out_col;
   logic                          frame_done;

   modport master (
      output in_valid, in_data,
      input  out_valid, out_win, out_row, out_col, frame_done
   );

   modport slave (
      input  in_valid, in_data,
      output out_valid, out_win, out_row, out_col, frame_done
   );
endinterface

// File: rtl/line_window_reader.sv
// Turns a raster pixel stream into 3x3 windows around every interior pixel,
// using two line memories and a 3x3 shift window; two-cycle accept-to-window latency.
module line_window_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input logic clock,
   input logic rst_n,
   line_window_reader_if.slave bus
);
   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   logic                    accept;
   logic [COL_W-1:0]        col;
   logic [ROW_W-1:0]        row;
   logic                    col_last;
   logic                    row_last;

   logic [DATA_WIDTH-1:0]   line0_mem [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]   line1_mem [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]   line0_rd;
   logic [DATA_WIDTH-1:0]   line1_rd;

   logic [DATA_WIDTH-1:0]   win [3][3];
   logic [9*DATA_WIDTH-1:0] win_flat;

   logic                    stage_valid;
   logic                    stage_last;
   logic [ROW_W-1:0]        stage_row;
   logic [COL_W-1:0]        stage_col;

   assign accept   = bus.in_valid;
   assign col_last = (col == COL_LAST);
   assign row_last = (row == ROW_LAST);
   assign line0_rd = line0_mem[col];
   assign line1_rd = line1_mem[col];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // Line memories shift one row down per accept; reads above see the pre-write contents.
   always_ff @(posedge clock) begin
      if (accept) begin
         line1_mem[col] <= line0_mem[col];
         line0_mem[col] <= bus.in_data;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= line1_rd;
         win[1][2] <= line0_rd;
         win[2][2] <= bus.in_data;
      end
   end

   always_comb begin
      win_flat = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            win_flat[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
         end
      end
   end

   // Only accepts with two rows and two columns behind them yield a window, which
   // keeps stale memory, left-edge wrap and previous-frame pixels out of the output.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         stage_valid <= 1'b0;
         stage_last  <= 1'b0;
         stage_row   <= '0;
         stage_col   <= '0;
      end else begin
         stage_valid <= accept && (row >= ROW_TWO) && (col >= COL_TWO);
         if (accept) begin
            stage_last <= row_last && col_last;
            stage_row  <= row - ROW_W'(1);
            stage_col  <= col - COL_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid  <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.out_win    <= '0;
         bus.out_row    <= '0;
         bus.out_col    <= '0;
      end else if (stage_valid) begin
         bus.out_valid  <= 1'b1;
         bus.frame_done <= stage_last;
         bus.out_win    <= win_flat;
         bus.out_row    <= stage_row;
         bus.out_col    <= stage_col;
      end else begin
         bus.out_valid  <= 1'b0;
         bus.frame_done <= 1'b0;
      end
   end
endmodule

// File: tb/tb_line_window_reader.sv
// Scoreboard bench for line_window_reader: an 8x6 instance (ramp, gaps, back-to-back, reset)
// and a 3x3 instance (minimum size), each checked against a frame-image reference model.
module tb_line_window_reader;
   localparam int DW = 8;

   typedef struct {
      logic [71:0] win;
      int          row;
      int          col;
      bit          fd;
      int          due;
   } exp_t;

   logic clock = 1'b0;
   logic rstA;
   logic rstB;
   int   cyc = 0;

   int   compared = 0;
   int   mismatched = 0;

   exp_t qA[$];
   exp_t qB[$];
   int   img [2][8][8];
   int   mr [2];
   int   mc [2];

   logic [71:0] lastWinA, lastWinB, firstWinA, firstWinB;
   int   lastRowA, lastColA, lastRowB, lastColB;
   int   firstRowA, firstColA, firstRowB, firstColB;
   bit   grabA, grabB;
   int   winCntA, fdCntA, winCntB, fdCntB;

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   line_window_reader_if #(.DATA_WIDTH(DW), .IMG_WIDTH(8), .IMG_HEIGHT(6)) busA ();
   line_window_reader_if #(.DATA_WIDTH(DW), .IMG_WIDTH(3), .IMG_HEIGHT(3)) busB ();

   line_window_reader #(.DATA_WIDTH(DW), .IMG_WIDTH(8), .IMG_HEIGHT(6)) dutA (
      .clock(clock), .rst_n(rstA), .bus(busA)
   );
   line_window_reader #(.DATA_WIDTH(DW), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dutB (
      .clock(clock), .rst_n(rstB), .bus(busB)
   );

   task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: store the accepted pixel in the frame image and, for interior
   // positions, predict the window read straight out of that image.
   task automatic modelAccept(input int id, input int pix);
      int w, h, r0, c0;
      exp_t e;
      w = (id == 0) ? 8 : 3;
      h = (id == 0) ? 6 : 3;
      r0 = mr[id];
      c0 = mc[id];
      img[id][r0][c0] = pix;
      if (r0 >= 2 && c0 >= 2) begin
         e.win = '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               e.win[(r*3+c)*8 +: 8] = 8'(img[id][r0-2+r][c0-2+c]);
         e.row = r0 - 1;
         e.col = c0 - 1;
         e.fd  = (r0 == h - 1) && (c0 == w - 1);
         e.due = cyc + 2;
         if (id == 0) qA.push_back(e);
         else qB.push_back(e);
      end
      mc[id] = (c0 + 1) % w;
      if (c0 == w - 1) mr[id] = (r0 + 1) % h;
   endtask

   task automatic driveIn(input int id, input bit v, input int pix);
      if (id == 0) begin
         busA.in_valid = v;
         busA.in_data  = 8'(pix);
      end else begin
         busB.in_valid = v;
         busB.in_data  = 8'(pix);
      end
   endtask

   // Sends one full frame; resetAfter >= 0 aborts with a one-cycle reset after that pixel index.
   task automatic applyStimulus(input int id, input int base, input int gapPct, input int resetAfter);
      int w, h, pix;
      w = (id == 0) ? 8 : 3;
      h = (id == 0) ? 6 : 3;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            @(posedge clock); #1;
            while (gapPct > 0 && $urandom_range(1, 100) <= gapPct) begin
               driveIn(id, 1'b0, 0);
               @(posedge clock); #1;
            end
            pix = (id == 0) ? base + r*16 + c : base + r*3 + c;
            driveIn(id, 1'b1, pix);
            modelAccept(id, pix);
            if (r*w + c == resetAfter) begin
               @(posedge clock); #1;
               driveIn(id, 1'b0, 0);
               rstA = 1'b0;
               qA.delete();
               lastWinA = '0; lastRowA = 0; lastColA = 0;
               mr[0] = 0; mc[0] = 0;
               #1;
               checkOutput("mid-reset out_valid", 72'(busA.out_valid), 72'd0);
               checkOutput("mid-reset out_win", busA.out_win, 72'd0);
               checkOutput("mid-reset out_row", 72'(busA.out_row), 72'd0);
               checkOutput("mid-reset out_col", 72'(busA.out_col), 72'd0);
               @(posedge clock); #1;
               rstA = 1'b1;
               return;
            end
         end
      end
   endtask

   task automatic idle(input int id, input int n);
      @(posedge clock); #1;
      driveIn(id, 1'b0, 0);
      repeat (n) @(posedge clock);
   endtask

   task automatic waitDrain(input int id);
      int left;
      left = 30;
      while (left > 0 && ((id == 0) ? qA.size() : qB.size()) != 0) begin
         @(posedge clock);
         left--;
      end
      checkOutput((id == 0) ? "A drain" : "B drain",
                  72'((id == 0) ? qA.size() : qB.size()), 72'd0);
   endtask

   always @(negedge clock) begin : monA
      exp_t e;
      if (rstA) begin
         if (busA.out_valid) begin
            if (qA.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL A unexpected window: row %0d col %0d win %0h, expected none",
                        busA.out_row, busA.out_col, busA.out_win);
            end else begin
               e = qA.pop_front();
               checkOutput("A latency", 72'(cyc), 72'(e.due));
               checkOutput("A out_win", busA.out_win, e.win);
               checkOutput("A out_row", 72'(busA.out_row), 72'(e.row));
               checkOutput("A out_col", 72'(busA.out_col), 72'(e.col));
               checkOutput("A frame_done", 72'(busA.frame_done), 72'(e.fd));
               lastWinA = e.win; lastRowA = e.row; lastColA = e.col;
               if (grabA) begin
                  firstWinA = busA.out_win;
                  firstRowA = int'(busA.out_row);
                  firstColA = int'(busA.out_col);
                  grabA = 1'b0;
               end
               winCntA++;
               if (busA.frame_done) fdCntA++;
            end
         end else begin
            checkOutput("A hold out_win", busA.out_win, lastWinA);
            checkOutput("A hold out_row", 72'(busA.out_row), 72'(lastRowA));
            checkOutput("A hold out_col", 72'(busA.out_col), 72'(lastColA));
            checkOutput("A idle frame_done", 72'(busA.frame_done), 72'd0);
         end
      end
   end

   always @(negedge clock) begin : monB
      exp_t e;
      if (rstB) begin
         if (busB.out_valid) begin
            if (qB.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL B unexpected window: row %0d col %0d win %0h, expected none",
                        busB.out_row, busB.out_col, busB.out_win);
            end else begin
               e = qB.pop_front();
               checkOutput("B latency", 72'(cyc), 72'(e.due));
               checkOutput("B out_win", busB.out_win, e.win);
               checkOutput("B out_row", 72'(busB.out_row), 72'(e.row));
               checkOutput("B out_col", 72'(busB.out_col), 72'(e.col));
               checkOutput("B frame_done", 72'(busB.frame_done), 72'(e.fd));
               lastWinB = e.win; lastRowB = e.row; lastColB = e.col;
               if (grabB) begin
                  firstWinB = busB.out_win;
                  firstRowB = int'(busB.out_row);
                  firstColB = int'(busB.out_col);
                  grabB = 1'b0;
               end
               winCntB++;
               if (busB.frame_done) fdCntB++;
            end
         end else begin
            checkOutput("B hold out_win", busB.out_win, lastWinB);
            checkOutput("B idle frame_done", 72'(busB.frame_done), 72'd0);
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstA = 1'b0; rstB = 1'b0;
      busA.in_valid = 1'b0; busA.in_data = '0;
      busB.in_valid = 1'b0; busB.in_data = '0;
      mr[0] = 0; mc[0] = 0; mr[1] = 0; mc[1] = 0;
      lastWinA = '0; lastRowA = 0; lastColA = 0;
      lastWinB = '0; lastRowB = 0; lastColB = 0;
      firstWinA = '0; firstWinB = '0;
      firstRowA = -1; firstColA = -1; firstRowB = -1; firstColB = -1;
      grabA = 1'b0; grabB = 1'b0;
      winCntA = 0; fdCntA = 0; winCntB = 0; fdCntB = 0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset out_valid", 72'(busA.out_valid), 72'd0);
      checkOutput("reset frame_done", 72'(busA.frame_done), 72'd0);
      checkOutput("reset out_win", busA.out_win, 72'd0);
      checkOutput("reset out_row", 72'(busA.out_row), 72'd0);
      checkOutput("reset out_col", 72'(busA.out_col), 72'd0);
      checkOutput("reset B out_valid", 72'(busB.out_valid), 72'd0);
      rstA = 1'b1; rstB = 1'b1;

      $display("[TB] ramp frame, continuous input");
      grabA = 1'b1;
      applyStimulus(0, 0, 0, -1);
      idle(0, 4);
      waitDrain(0);
      checkOutput("ramp window count", 72'(winCntA), 72'd24);
      checkOutput("ramp frame_done count", 72'(fdCntA), 72'd1);
      checkOutput("ramp first window", firstWinA, 72'h222120121110020100);
      checkOutput("ramp first row", 72'(firstRowA), 72'd1);
      checkOutput("ramp first col", 72'(firstColA), 72'd1);

      $display("[TB] ramp frame, gapped input");
      winCntA = 0; fdCntA = 0;
      applyStimulus(0, 0, 50, -1);
      idle(0, 4);
      waitDrain(0);
      checkOutput("gapped window count", 72'(winCntA), 72'd24);
      checkOutput("gapped frame_done count", 72'(fdCntA), 72'd1);

      $display("[TB] back-to-back frames");
      winCntA = 0; fdCntA = 0;
      applyStimulus(0, 0, 0, -1);
      applyStimulus(0, 'h80, 0, -1);
      idle(0, 4);
      waitDrain(0);
      checkOutput("b2b window count", 72'(winCntA), 72'd48);
      checkOutput("b2b frame_done count", 72'(fdCntA), 72'd2);

      $display("[TB] reset mid-frame");
      applyStimulus(0, 0, 0, 3*8 + 4);
      winCntA = 0; fdCntA = 0;
      applyStimulus(0, 'h40, 25, -1);
      idle(0, 4);
      waitDrain(0);
      checkOutput("post-reset window count", 72'(winCntA), 72'd24);
      checkOutput("post-reset frame_done count", 72'(fdCntA), 72'd1);

      $display("[TB] minimum 3x3 frame");
      grabB = 1'b1;
      applyStimulus(1, 1, 0, -1);
      idle(1, 4);
      waitDrain(1);
      checkOutput("min window count", 72'(winCntB), 72'd1);
      checkOutput("min frame_done count", 72'(fdCntB), 72'd1);
      checkOutput("min window", firstWinB, 72'h090807060504030201);
      checkOutput("min row", 72'(firstRowB), 72'd1);
      checkOutput("min col", 72'(firstColB), 72'd1);

      winCntB = 0;
      applyStimulus(1, $urandom_range(0, 200), 50, -1);
      idle(1, 4);
      waitDrain(1);
      checkOutput("min random window count", 72'(winCntB), 72'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/line_window_reader.md
Name: line_window_reader

Overview:
- Consumes a raster pixel stream and emits the 3x3 neighbourhood of every interior pixel, one window per accepted pixel once two full lines are buffered.
- Sits after the delay-line buffering stage in the image/feature-map path and feeds 3x3 conv and pool engines.
- Internally holds two single-port-style line memories of IMG_WIDTH entries each (read-before-write per address) plus a 3x3 register window.
- Output is valid-mode: (IMG_HEIGHT-2) x (IMG_WIDTH-2) windows per frame, with no padding.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- IMG_WIDTH, 640, pixels per line (>=3).
- IMG_HEIGHT, 480, lines per frame (>=3).

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  pixel accept strobe; no backpressure, every high cycle accepts one pixel.
- in_data  in  DATA_WIDTH  pixel in raster order.
- out_valid  out  1  window valid, one-cycle pulse per window.
- out_win  out  9*DATA_WIDTH  window; element (r,c) at bits [(r*3+c)*DATA_WIDTH +: DATA_WIDTH], with r=0 as the oldest row and c=0 as the oldest column.
- out_row  out  $clog2(IMG_HEIGHT)  row of the window centre.
- out_col  out  $clog2(IMG_WIDTH)  column of the window centre.
- frame_done  out  1  pulses together with the last window of a frame.

Behaviour:
- Reset (async assert, sync release):
  - col, row, out_valid, frame_done, out_win, out_row and out_col all clear to 0.
  - Line memory contents are not cleared.
- Counters advance only on in_valid:
  - col wraps IMG_WIDTH-1 -> 0 and then increments row.
  - row wraps IMG_HEIGHT-1 -> 0 at end of frame.
  - The next accepted pixel after the wrap is (0,0) of a new frame.
- Line memories:
  - On each accept at address col, line0 reads the pixel from the row above and line1 reads the pixel from two rows above.
  - In the same cycle, line1[col] <= old line0[col] and line0[col] <= in_data.
  - The read must return the pre-write value.
- Window:
  - On each accepted pixel, the three column registers shift left by one column.
  - The new column is {line1 out, line0 out, in_data} for r=0,1,2.
- Window contents for the accepted pixel at (R,C): element (r,c) = pixel (R-2+r, C-2+c).
- Output gating:
  - A window is produced only if R>=2 and C>=2.
  - Stale memory contents, left-edge wrap columns and the previous frame never produce a window.
- Latency:
  - Pixel accepted at cycle t produces out_valid=1 at cycle t+2.
  - out_win, out_row=R-1 and out_col=C-1 are stable in that same cycle.
- Output hold and stalls:
  - out_valid is high for exactly one cycle per window.
  - out_win, out_row and out_col hold their last values while out_valid=0.
  - in_valid gaps of any length only delay the outputs; window contents are unchanged.
- frame_done is high in the same cycle as the window for (R,C) = (IMG_HEIGHT-1, IMG_WIDTH-1).
- Back-to-back frames (pixel (0,0) accepted the cycle after the last pixel of the previous frame):
  - The last window of the old frame is still emitted at t+2.
  - The first window of the new frame waits until pixel (2,2) is accepted.
- Reset mid-frame:
  - The pipeline is flushed and no pending out_valid is emitted.
  - The next accepted pixel is treated as (0,0).

Test Plan:
- Ramp basic:
  - Stimulus: IMG_WIDTH=8, IMG_HEIGHT=6, pixel = row*16+col, in_valid held high.
  - Response: first out_valid exactly 2 cycles after pixel (2,2) is accepted.
  - First window = {00,01,02,10,11,12,20,21,22} (hex), out_row=1, out_col=1.
  - Exactly 24 windows per frame; frame_done only on the window centred at (4,6).
- Gapped input: same frame with in_valid randomly low ~50% of cycles -> identical window sequence and coordinates to the ramp test; each out_valid is 2 cycles after its triggering accept.
- Back-to-back frames:
  - Stimulus: two 8x6 frames, second frame is pixel = 0x80 + row*16 + col.
  - Response: 48 windows in total, with no window mixing frames.
  - First window of frame 2 = {80,81,82,90,91,92,A0,A1,A2}.
- Reset mid-frame: assert rst_n=0 after pixel (3,4) for 1 cycle, then send a full new frame -> no out_valid during or after the reset until the new pixel (2,2); windows are correct from then on.
- Minimum size: IMG_WIDTH=3, IMG_HEIGHT=3, pixels 1..9 -> exactly one window {1..9}, with out_row=1, out_col=1 and frame_done=1.
- Line-edge wrap: 8x6 ramp -> no window is emitted for C=0 or C=1 on any row, so no window contains pixels from two different lines.
